// File: rtl/display_demultiplexer.sv
// display_demultiplexer
// Rebuilds the four digits of a multiplexed 7-segment drive (anode enables
// plus a shared hex/dp bus) into four stable {dp,hex} registers. A digit is
// captured only after the scanned bus is stable for SETTLE samples.
// Optional build macro: DISPLAY_DEMUX_SYNC_EN adds a two-flop input
// synchronizer in front of the sample register (two extra cycles of latency).
//
// This block has no valid/ready handshake. The inputs are sampled
// unconditionally every cycle. frame_valid_o and err_o are single-cycle
// pulses that are not held and need no acknowledge.
module display_demultiplexer #(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT_W = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] an_i,
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    output logic [4:0] out0_o,
    output logic [4:0] out1_o,
    output logic [4:0] out2_o,
    output logic [4:0] out3_o,
    output logic       frame_valid_o,
    output logic [7:0] frame_count_o,
    output logic       err_o,
    output logic       stale_o,
    output logic       dbg_state_o,
    output logic [3:0] dbg_seen_o
);

    typedef enum logic {
        SETTLING = 1'b0,
        CAPTURED = 1'b1
    } state_t;

    // The capture happens on the edge where the stable count would reach SETTLE-1.
    localparam logic [3:0]           CNT_LAST = 4'(SETTLE - 2);
    localparam logic [TIMEOUT_W-1:0] TO_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0] TO_NEAR  = TO_MAX - 1'b1;

    logic [8:0]           w_in;
    logic [8:0]           r_sample;
    logic [8:0]           r_prev;
    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;
    logic                 w_capture;
    logic                 w_same;
    logic [3:0]           w_an;
    logic                 w_valid;
    logic [1:0]           w_idx;
    logic                 w_valid_cap;
    logic                 w_err_cap;
    logic [3:0]           w_seen_set;
    logic                 w_frame_done;
    logic [4:0]           r_out [4];
    logic [3:0]           r_seen;
    logic                 r_fv;
    logic                 r_err;
    logic [7:0]           r_fc;
    logic [TIMEOUT_W-1:0] r_to;
    logic                 r_stale;

`ifdef DISPLAY_DEMUX_SYNC_EN
    logic [8:0] r_sync1;
    logic [8:0] r_sync2;

    // Two-flop synchronizer. Resets to a blank display (all anodes off).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 9'b1111_0000_0;
            r_sync2 <= 9'b1111_0000_0;
        end else begin
            r_sync1 <= {an_i, hex_i, dp_i};
            r_sync2 <= r_sync1;
        end
    end
    assign w_in = r_sync2;
`else
    assign w_in = {an_i, hex_i, dp_i};
`endif

    // Sample register plus a one-deep history that feeds the stability compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sample <= '0;
            r_prev   <= '0;
        end else begin
            r_sample <= w_in;
            r_prev   <= r_sample;
        end
    end

    assign w_same = (r_sample == r_prev);
    assign w_an   = r_sample[8:5];

    // State register and stable-sample counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SETTLING;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: count stable samples, capture once, then wait for a change.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            SETTLING: begin
                if (!w_same) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = CAPTURED;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            CAPTURED: begin
                if (!w_same) begin
                    w_cnt_next   = '0;
                    w_state_next = SETTLING;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = SETTLING;
            end
        endcase
    end

    // Decode the anode pattern. Only a single active-low bit selects a digit.
    always_comb begin
        w_valid = 1'b0;
        w_idx   = 2'd0;
        case (w_an)
            4'b1110: begin w_valid = 1'b1; w_idx = 2'd0; end
            4'b1101: begin w_valid = 1'b1; w_idx = 2'd1; end
            4'b1011: begin w_valid = 1'b1; w_idx = 2'd2; end
            4'b0111: begin w_valid = 1'b1; w_idx = 2'd3; end
            default: begin w_valid = 1'b0; w_idx = 2'd0; end
        endcase
    end

    assign w_valid_cap  = w_capture & w_valid;
    assign w_err_cap    = w_capture & ~w_valid & (w_an != 4'b1111);
    assign w_seen_set   = r_seen | (4'b0001 << w_idx);
    assign w_frame_done = w_valid_cap & (w_seen_set == 4'b1111);

    // Digit registers, frame tracking, and the no-activity timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) r_out[i] <= '0;
            r_seen  <= '0;
            r_fv    <= 1'b0;
            r_err   <= 1'b0;
            r_fc    <= '0;
            r_to    <= '0;
            r_stale <= 1'b1;
        end else begin
            r_fv  <= w_frame_done;
            r_err <= w_err_cap;
            if (w_valid_cap) begin
                // A valid capture takes priority over a timeout on the same edge.
                r_out[w_idx] <= {r_sample[0], r_sample[4:1]};
                r_to         <= '0;
                r_stale      <= 1'b0;
                if (w_frame_done) begin
                    r_seen <= '0;
                    r_fc   <= r_fc + 8'd1;
                end else begin
                    r_seen <= w_seen_set;
                end
            end else begin
                if (r_to != TO_MAX) r_to <= r_to + 1'b1;
                if (r_to == TO_NEAR) begin
                    r_stale <= 1'b1;
                    r_seen  <= '0;
                end
            end
        end
    end

    assign out0_o        = r_out[0];
    assign out1_o        = r_out[1];
    assign out2_o        = r_out[2];
    assign out3_o        = r_out[3];
    assign frame_valid_o = r_fv;
    assign frame_count_o = r_fc;
    assign err_o         = r_err;
    assign stale_o       = r_stale;
    assign dbg_state_o   = r_state;
    assign dbg_seen_o    = r_seen;

endmodule

// File: doc/display_demultiplexer.md
DISPLAY_DEMULTIPLEXER -- requirements
Module: display_demultiplexer

Interface
REQ-001 SHALL have parameter SETTLE, 4, number of consecutive identical samples (2..15) required before a digit is captured.
REQ-002 SHALL have parameter TIMEOUT_W, 20, width of the no-activity timeout counter.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port an_i  input  4  scanned anode enables, active-low, one digit per bit.
REQ-006 SHALL have port hex_i  input  4  scanned digit value.
REQ-007 SHALL have port dp_i  input  1  scanned decimal point.
REQ-008 SHALL have ports out0_o, out1_o, out2_o, out3_o  output  5 each  reconstructed digit {dp,hex} for anode bit 0..3.
REQ-009 SHALL have port frame_valid_o  output  1  one-cycle pulse when all four digits have been captured.
REQ-010 SHALL have port frame_count_o  output  8  count of completed frames.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on an illegal stable anode pattern.
REQ-012 SHALL have port stale_o  output  1  level; no valid capture within timeout.

Function
REQ-013 SHALL register {an_i,hex_i,dp_i} every cycle into a 9-bit sample register; all outputs registered.
REQ-014 SHALL implement FSM SETTLING/CAPTURED; SETTLING counts consecutive cycles where sample equals previous sample; any difference clears the count.
REQ-015 SHALL, in SETTLING, perform the capture action on the edge where count reaches SETTLE-1 with no change, then enter CAPTURED.
REQ-016 SHALL, in CAPTURED, hold with no further capture until the sample changes, then enter SETTLING with count 0.
REQ-017 Capture action, anode exactly one bit low: write {dp,hex} into the matching outN_o and set seen[N].
REQ-018 Capture action, anode 4'b1111 (blank): no write, no error.
REQ-019 Capture action, any other anode pattern: no write, err_o pulsed for one cycle.
REQ-020 Latency: inputs constant from edge k yield updated outN_o visible after edge k+SETTLE.
REQ-021 Re-capture of a digit already in seen SHALL overwrite outN_o and leave seen unchanged.
REQ-022 When a capture sets the last missing seen bit, frame_valid_o SHALL pulse in the same cycle the updated outN_o appears, seen cleared to 4'b0000, and frame_count_o incremented, wrapping 255 to 0.
REQ-023 Timeout counter SHALL clear on every valid capture, otherwise increment, saturating at 2^TIMEOUT_W-1.
REQ-024 On reaching saturation, stale_o SHALL assert and seen SHALL clear; stale_o deasserts on the edge of the next valid capture.
REQ-025 Simultaneous valid capture and timeout saturation: capture wins; counter clears, stale_o stays 0.

Reset
REQ-026 rst_ni low SHALL immediately clear outN_o to 5'b0, frame_valid_o, err_o, seen, frame_count_o, counters and sample to 0, set FSM to SETTLING, and set stale_o to 1.
REQ-027 Reset asserted mid-settle or mid-frame SHALL discard partial state; no frame_valid_o pulse at or after deassertion without four new captures.

Configuration
REQ-028 With DISPLAY_DEMUX_SYNC_EN defined, an_i/hex_i/dp_i SHALL pass through a two-flop synchronizer (reset to an=4'b1111, hex=0, dp=0) before the sample register, adding 2 cycles to REQ-020 latency.
REQ-029 Without DISPLAY_DEMUX_SYNC_EN, inputs SHALL feed the sample register directly.

Verification (SETTLE=4, TIMEOUT_W=8, macro undefined)
REQ-030 Drive an=1110,hex=5,dp=1 for 10 cycles -> out0_o=5'h15 after 4th edge, exactly one capture, seen=0001, no frame_valid_o.
REQ-031 Scan digits 0..3 with values 1,2,3,4, 6 cycles each -> frame_valid_o single pulse with out3_o=4, frame_count_o=1.
REQ-032 Toggle hex every 3 cycles with an=1101 -> out1_o never changes.
REQ-033 Hold an=1100 for 6 cycles -> one err_o pulse, all outN_o unchanged; an=1111 held -> no err_o.
REQ-034 After a capture, hold an=1111 for 255 cycles -> stale_o=1, seen cleared; next valid capture -> stale_o=0.
REQ-035 Assert rst_ni low after 3 of 4 digits -> outputs reset instantly; next frame_valid_o only after 4 fresh captures, frame_count_o=1.
